// File: rtl/rv_pkg.sv
// Shared constants and types for the rv_dmem data-side block.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv_pkg;

  // Peripheral register offsets inside the 16-byte MMIO window
  localparam logic [3:0] TX_DATA_OFF  = 4'h0;
  localparam logic [3:0] STATUS_OFF   = 4'h4;
  localparam logic [3:0] MTIME_OFF    = 4'h8;
  localparam logic [3:0] MTIMECMP_OFF = 4'hC;

  // STATUS register bit positions
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 4;
  localparam int STAT_CNT_MSB   = 7;

  // Address decoder result
  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Latency: a pushed entry is visible at the head one cycle later; no bypass.
// Backpressure: push is accepted when not full or when a pop occurs in the same cycle.
module rv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_dat  = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since the count gates visibility
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/rv_dmem.sv
// Data RAM, console TX FIFO and optional machine timer (enabled by RV_DMEM_TIMER_EN).
// Latency: reads combinational same cycle; writes, FIFO and timer update on the rising edge.
// Backpressure: tx_valid_o/tx_ready_i on the FIFO head; pushes into a full FIFO drop and set overflow.
module rv_dmem
  import rv_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  input  logic        data_we_i,
  output logic [31:0] data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        irq_o
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

  region_e       region;
  logic [3:0]    off;
  logic [AW-1:0] ram_idx;
  logic          wr_en;
  logic          mmio_wr;
  logic [31:0]   ram [MEM_WORDS];

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ovf;
  logic [31:0]   status;

  // Byte lane bits are ignored: every access is a full word
  assign off     = {data_addr_i[3:2], 2'b00};
  assign ram_idx = data_addr_i[AW+1:2];
  assign wr_en   = rst_ni && data_we_i;
  assign mmio_wr = wr_en && (region == REG_MMIO);

  // Address decode; RAM sits at the bottom, the MMIO window at MMIO_BASE
  always_comb begin
    region = REG_NONE;
    if ({1'b0, data_addr_i} < RAM_BYTES)                 region = REG_RAM;
    else if (data_addr_i[31:4] == MMIO_BASE[31:4])       region = REG_MMIO;
  end

  // RAM write port; the read port below sees the pre-write word in the same cycle
  always_ff @(posedge clk_i) begin
    if (wr_en && (region == REG_RAM)) ram[ram_idx] <= data_i;
  end

  assign fifo_push  = mmio_wr && (off == TX_DATA_OFF);
  assign fifo_pop   = tx_valid_o && tx_ready_i;
  assign tx_valid_o = !fifo_empty;

  rv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .wr_dat (data_i[7:0]),
    .pop    (fifo_pop),
    .rd_dat (tx_data_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Sticky overflow: a dropped push sets it, writing 1 to its STATUS bit clears it
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                  ovf <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) ovf <= 1'b1;
    else if (mmio_wr && (off == STATUS_OFF) && data_i[STAT_OVF_BIT]) ovf <= 1'b0;
  end

  // STATUS word assembly; count is resized to the 4-bit field
  always_comb begin
    status                              = '0;
    status[STAT_FULL_BIT]               = fifo_full;
    status[STAT_EMPTY_BIT]              = fifo_empty;
    status[STAT_OVF_BIT]                = ovf;
    status[STAT_CNT_MSB:STAT_CNT_LSB]   = 4'(fifo_count);
  end

`ifdef RV_DMEM_TIMER_EN
  logic [31:0] mtime;
  logic [31:0] mtimecmp;
  logic        irq_q;

  // Free-running timer; a software write to MTIME overrides the increment
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime    <= '0;
      mtimecmp <= 32'hFFFF_FFFF;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= (mtime >= mtimecmp);
      if (mmio_wr && (off == MTIME_OFF)) mtime <= data_i;
      else                               mtime <= mtime + 32'd1;
      if (mmio_wr && (off == MTIMECMP_OFF)) mtimecmp <= data_i;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Combinational read mux back to the core
  always_comb begin
    data_o = '0;
    case (region)
      REG_RAM:  data_o = ram[ram_idx];
      REG_MMIO: begin
        case (off)
          STATUS_OFF:   data_o = status;
`ifdef RV_DMEM_TIMER_EN
          MTIME_OFF:    data_o = mtime;
          MTIMECMP_OFF: data_o = mtimecmp;
`endif
          default:      data_o = '0;
        endcase
      end
      default:  data_o = '0;
    endcase
  end

endmodule
